mem_arbiter: RTL and testbench

//  Shares the single memory/IO port between the instruction-fetch requester
//  (driven by control in STATE_FETCH) and the data requester (STATE_LOAD /

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared memory/IO port: fetch vs. data.
// Data wins contention; a starvation counter forces a pending fetch after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ack,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  grant_q, grant_d;  // 1 = data requester owns the access
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  pick_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    pick_data    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (f_req || d_req) begin
          // A fetch that has sat through STARVE_LIMIT data grants goes first.
          pick_data  = d_req && !(f_req && (starve_cnt_q == SW'(STARVE_LIMIT)));
          grant_d    = pick_data;
          wait_cnt_d = WW'(WAIT_STATES);
          state_d    = ST_ACCESS;
          if (pick_data) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            if (!f_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
              starve_cnt_d = starve_cnt_q + SW'(1);
            end
          end else begin
            addr_d       = f_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
            starve_cnt_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WW'(1);
        end else begin
          if (!we_q) begin
            if (grant_q) d_rdata_d = mem_rdata;
            else         f_rdata_d = mem_rdata;
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are zero outside ACCESS so idle cycles are unambiguous on the port.
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign f_ack     = (state_q == ST_ACK) & ~grant_q;
  assign d_ack     = (state_q == ST_ACK) & grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, random traffic
// against a transaction-level memory/arbitration model, and a zero-wait-state instance.
module tb_mem_arbiter;

  localparam int WS = 1;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        f_req, d_req, d_we, f_ack, d_ack, mem_en, mem_we, busy;
  logic [15:0] f_addr, d_addr, d_wdata, f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        z_f_req, z_d_req, z_d_we, z_f_ack, z_d_ack, z_mem_en, z_mem_we, z_busy;
  logic [15:0] z_f_addr, z_d_addr, z_d_wdata, z_f_rdata, z_d_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut0 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(0), .STARVE_LIMIT(SL)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(z_f_req), .f_addr(z_f_addr), .f_ack(z_f_ack), .f_rdata(z_f_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata), .d_ack(z_d_ack),
    .d_rdata(z_d_rdata), .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  // Memory environment: combinational read, write on the clock edge.
  logic [15:0] mem0 [0:4095];
  logic [15:0] mem1 [0:255];
  logic [15:0] ref_mem [0:511];
  assign mem_rdata   = mem0[mem_addr[11:0]];
  assign z_mem_rdata = mem1[z_mem_addr[7:0]];
  always @(posedge clk) if (mem_en && mem_we) mem0[mem_addr[11:0]] = mem_wdata;
  always @(posedge clk) if (z_mem_en && z_mem_we) mem1[z_mem_addr[7:0]] = z_mem_wdata;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37 + 16'h1357);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request from idle; returns latency in cycles, ACCESS length, bus errors, stray acks.
  task automatic txn(input bit is_f, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                     output int lat, output int en_cyc, output int bad_bus, output int other_ack,
                     output int pulse_ok);
    bit got;
    @(negedge clk);
    if (is_f) begin f_req = 1'b1; f_addr = addr; end
    else begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    lat = 0; en_cyc = 0; bad_bus = 0; other_ack = 0; got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        en_cyc++;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) bad_bus++;
      end
      if (is_f ? d_ack : f_ack) other_ack++;
      if (is_f ? f_ack : d_ack) got = 1'b1;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    pulse_ok = (f_ack === 1'b0 && d_ack === 1'b0) ? 1 : 0;
  endtask

  task automatic do_txn(input string name, input bit is_f, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_f, input logic [15:0] exp_d);
    int lat, en_cyc, bad_bus, other_ack, pulse_ok;
    txn(is_f, we, addr, wdata, lat, en_cyc, bad_bus, other_ack, pulse_ok);
    check($sformatf("%s latency", name), lat, WS + 2);
    check($sformatf("%s access_len", name), en_cyc, WS + 1);
    check($sformatf("%s bus", name), bad_bus, 0);
    check($sformatf("%s stray_ack", name), other_ack, 0);
    check($sformatf("%s ack_pulse", name), pulse_ok, 1);
    check($sformatf("%s f_rdata", name), f_rdata, exp_f);
    check($sformatf("%s d_rdata", name), d_rdata, exp_d);
  endtask

  typedef struct {
    bit          is_f;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_f;
    logic [15:0] exp_d;
  } vec_t;
  vec_t vecs[8];

  // Arbitration model for random traffic: reqs sampled at each edge, checked at each new grant.
  logic f_s = 1'b0, d_s = 1'b0, rand_on = 1'b0, en_prev = 1'b0;
  int   streak = 0, run_len = 0;
  logic [15:0] f_exp_q[$];
  logic [15:0] d_exp_q[$];

  always @(posedge clk) begin
    f_s <= f_req;
    d_s <= d_req;
  end

  always @(negedge clk) begin
    if (rand_on) begin
      if (mem_en && !en_prev) begin
        bit is_data, exp_data;
        is_data  = mem_addr[8];
        exp_data = d_s && !(f_s && streak == SL);
        check("rand grantee", is_data, exp_data);
        if (exp_data && f_s) streak = (streak < SL) ? streak + 1 : SL;
        else                 streak = 0;
        run_len = 0;
      end
      if (mem_en) run_len++;
      if (!mem_en && en_prev) check("rand access_len", run_len, WS + 1);
      en_prev = mem_en;
    end
  end

  task automatic fetch_drv();
    for (int i = 0; i < 25; i++) begin
      int a, n;
      bit got;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      a = $urandom_range(16'h080, 16'h0ff);
      f_addr = 16'(a);
      f_req  = 1'b1;
      f_exp_q.push_back(ref_mem[a]);
      n = 0; got = 1'b0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (f_ack) got = 1'b1;
      end
      f_req = 1'b0;
      check("rand f_ack seen", got, 1);
      if (got && f_exp_q.size() > 0) check("rand f_rdata", f_rdata, f_exp_q.pop_front());
    end
  endtask

  task automatic data_drv();
    logic [15:0] d_last = 16'h0000;
    for (int i = 0; i < 25; i++) begin
      int a, n;
      bit got, we;
      logic [15:0] wd;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      a  = $urandom_range(16'h100, 16'h11f);
      we = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if (we) ref_mem[a] = wd;
      else    d_last = ref_mem[a];
      d_exp_q.push_back(d_last);
      d_addr = 16'(a); d_we = we; d_wdata = wd; d_req = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (d_ack) got = 1'b1;
      end
      d_req = 1'b0;
      check("rand d_ack seen", got, 1);
      if (got && d_exp_q.size() > 0) check("rand d_rdata", d_rdata, d_exp_q.pop_front());
    end
  endtask

  initial begin
    int d_idx, f_idx, d_cnt, f_cnt, d_left, d_acks, f_pos, starve_seen, acks, lat, busy_cnt, en_cnt;
    bit f_done;

    vecs[0] = '{1'b0, 1'b1, 16'h0400, 16'h1111, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h1111};
    vecs[2] = '{1'b0, 1'b1, 16'h0401, 16'hBEEF, 16'h0000, 16'h1111};
    vecs[3] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h1111, 16'h1111};
    vecs[4] = '{1'b0, 1'b0, 16'h0401, 16'h0000, 16'h1111, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b1, 16'h0400, 16'h0000, 16'h1111, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 16'h1111, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0401, 16'h0000, 16'hBEEF, 16'h0000};

    for (int i = 0; i < 4096; i++) mem0[i] = init_val(i);
    for (int i = 0; i < 512; i++)  ref_mem[i] = init_val(i);
    for (int i = 0; i < 256; i++)  mem1[i] = 16'h0000;
    mem0[16'h0010] = 16'hABCD;
    mem0[16'h0004] = 16'h0044;
    mem0[16'h0300] = 16'h3300;
    mem1[8'h20]    = 16'h2222;

    // Clock/reset
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    z_f_req = 1'b0; z_f_addr = '0; z_d_req = 1'b0; z_d_we = 1'b0; z_d_addr = '0; z_d_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset acks", {f_ack, d_ack}, 0);
    check("reset rdata", {f_rdata, d_rdata}, 0);
    check("reset mem bus", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("reset busy", {busy, z_busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].is_f, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_f, vecs[i].exp_d);

    do_txn("t1 fetch", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 16'h0000);
    do_txn("t2 write", 1'b0, 1'b1, 16'h0200, 16'h1234, 16'hABCD, 16'h0000);
    check("t2 mem written", mem0[16'h0200], 16'h1234);

    // Simultaneous requests: data first, fetch after one idle cycle.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    f_req = 1'b1; f_addr = 16'h0004;
    d_idx = 0; f_idx = 0; d_cnt = 0; f_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (d_ack) begin d_cnt++; d_idx = k; d_req = 1'b0; end
      if (f_ack) begin f_cnt++; f_idx = k; f_req = 1'b0; end
    end
    check("t3 d_ack cycle", d_idx, WS + 2);
    check("t3 f_ack cycle", f_idx, 2 * WS + 5);
    check("t3 ack counts", {16'(d_cnt), 16'(f_cnt)}, {16'd1, 16'd1});
    check("t3 d_rdata", d_rdata, 16'h3300);
    check("t3 f_rdata", f_rdata, 16'h0044);

    // Back-to-back data with fetch held: fetch forced after SL data grants.
    @(negedge clk);
    d_left = 5; d_acks = 0; f_pos = -1; starve_seen = -1; f_done = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0105;
    f_req = 1'b1; f_addr = 16'h0010;
    for (int k = 0; k < 200 && !(d_left == 0 && f_done); k++) begin
      @(negedge clk);
      if (d_ack) begin
        d_req = 1'b0; d_left--; d_acks++;
      end else if (!d_req && d_left > 0) begin
        d_req = 1'b1; d_addr = 16'(16'h0100 + d_left);
      end
      if (f_ack) begin
        f_pos = d_acks; starve_seen = int'(dut0.starve_cnt_q); f_req = 1'b0; f_done = 1'b1;
      end
    end
    d_req = 1'b0; f_req = 1'b0;
    check("t4 data acks", d_acks, 5);
    check("t4 fetch position", f_pos, SL);
    check("t4 starve cleared", starve_seen, 0);
    check("t4 f_rdata", f_rdata, 16'hABCD);

    // Asynchronous reset in the middle of a read access.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0120;
    @(negedge clk);
    check("t5 in access", {busy, mem_en}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("t5 rst bus", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("t5 rst busy/acks", {busy, f_ack, d_ack}, 0);
    check("t5 rst rdata", {f_rdata, d_rdata}, 0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (f_ack || d_ack) acks++;
    end
    check("t5 no ack after abort", acks, 0);
    do_txn("t5 post fetch", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 16'h0000);

    // Random traffic from both requesters.
    rand_on = 1'b1;
    fork
      fetch_drv();
      data_drv();
    join
    repeat (3) @(negedge clk);
    rand_on = 1'b0;

    // Zero-wait-state instance.
    @(negedge clk);
    z_f_req = 1'b1; z_f_addr = 16'h0020;
    lat = 0; busy_cnt = 0; en_cnt = 0; acks = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (z_busy) busy_cnt++;
      if (z_mem_en) en_cnt++;
      if (z_d_ack) acks += 100;
      if (z_f_ack) begin acks++; if (lat == 0) lat = k; z_f_req = 1'b0; end
    end
    check("t6 latency", lat, 2);
    check("t6 busy cycles", busy_cnt, 2);
    check("t6 access_len", en_cnt, 1);
    check("t6 acks", acks, 1);
    check("t6 f_rdata", z_f_rdata, 16'h2222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
